// File: rtl/hazard_detection_unit_pkg.sv
// Shared definitions for the ID-stage hazard controller: FSM encoding, register
// address width and the load-use comparator.
package hazard_detection_unit_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } hdu_state_t;

  // $zero is hard-wired, so a load targeting it can never create a dependency.
  function automatic logic load_use_hit(
    input logic                  mem_read,
    input logic [REG_ADDR_W-1:0] ld_rt,
    input logic [REG_ADDR_W-1:0] rs,
    input logic [REG_ADDR_W-1:0] rt,
    input logic                  uses_rt
  );
    return mem_read && (ld_rt != ZERO_REG) &&
           ((ld_rt == rs) || (uses_rt && (ld_rt == rt)));
  endfunction

endpackage

// File: rtl/hazard_detection_unit_sat_counter.sv
// Saturating event counter: holds at all-ones instead of wrapping.
// Latency: 1 cycle from en to q update. No backpressure; en is sampled every cycle.
// Cleared asynchronously by rst_n.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] ONE = W'(1);
  localparam logic [W-1:0] MAX = '1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en && (q != MAX)) begin
      q <= q + ONE;
    end
  end

endmodule

// File: rtl/hazard_detection_unit.sv
// ID-stage load-use stall and taken-branch flush controller with event counters.
// Latency: control outputs are combinational in the detecting cycle; state/counters update next edge.
// Backpressure: stalls PC and IF/ID for STALL_CYCLES cycles per load-use hazard; branch flush overrides.
module hazard_detection_unit
  import hazard_detection_unit_pkg::*;
#(
  parameter int STALL_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  idex_mem_read,
  input  logic [REG_ADDR_W-1:0] idex_rt,
  input  logic [REG_ADDR_W-1:0] ifid_rs,
  input  logic [REG_ADDR_W-1:0] ifid_rt,
  input  logic                  ifid_uses_rt,
  input  logic                  branch_taken,
  output logic                  ctrl_sel,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  ifid_flush,
  output logic                  exmem_flush,
  output logic [1:0]            state_o,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  localparam logic [2:0] REM_INIT   = 3'(STALL_CYCLES - 1);
  localparam bit         MULTI_STALL = (STALL_CYCLES > 1);

  hdu_state_t state, state_nxt;
  logic [2:0] rem, rem_nxt;
  logic       hz;
  logic       stall_now;
  logic       stall_en;
  logic       flush_en;

  assign hz        = load_use_hit(idex_mem_read, idex_rt, ifid_rs, ifid_rt, ifid_uses_rt);
  assign stall_now = (state == ST_STALL) || hz;
  assign state_o   = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
      rem   <= '0;
    end else begin
      state <= state_nxt;
      rem   <= rem_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rem_nxt   = rem;
    if (branch_taken) begin
      // A taken branch squashes the stalled instruction, so any remaining stall is moot.
      state_nxt = ST_FLUSH;
      rem_nxt   = '0;
    end else if (state == ST_STALL) begin
      rem_nxt = rem - 3'd1;
      if (rem == 3'd1) begin
        state_nxt = ST_RUN;
      end
    end else if (hz && MULTI_STALL) begin
      state_nxt = ST_STALL;
      rem_nxt   = REM_INIT;
    end else begin
      state_nxt = ST_RUN;
    end
  end

  always_comb begin
    ctrl_sel    = 1'b0;
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    ifid_flush  = 1'b0;
    exmem_flush = 1'b0;
    if (!rst_n) begin
      ctrl_sel = 1'b0;
    end else if (branch_taken) begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (!stall_now) begin
      ctrl_sel   = 1'b1;
      pc_write   = 1'b1;
      ifid_write = 1'b1;
    end
  end

  assign stall_en = rst_n && !branch_taken && stall_now;
  assign flush_en = rst_n && branch_taken;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (stall_en),
    .q     (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (flush_en),
    .q     (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Bench for hazard_detection_unit: vector table on a single-bubble instance plus
// multi-cycle sequences on a 3-bubble instance and a narrow-counter instance.
module tb_hazard_detection_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mr;
  logic [4:0] irt, rs, rt;
  logic       use_rt;
  logic       bt;

  logic cs1, pw1, iw1, if1, ef1;
  logic [1:0]  st1;
  logic [15:0] sc1, fc1;
  logic cs3, pw3, iw3, if3, ef3;
  logic [1:0]  st3;
  logic [15:0] sc3, fc3;
  logic cs4, pw4, iw4, if4, ef4;
  logic [1:0]  st4;
  logic [3:0]  sc4, fc4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_detection_unit #(.STALL_CYCLES(1), .CNT_W(16)) u1 (
    .clk(clk), .rst_n(rst_n), .idex_mem_read(mr), .idex_rt(irt), .ifid_rs(rs),
    .ifid_rt(rt), .ifid_uses_rt(use_rt), .branch_taken(bt), .ctrl_sel(cs1),
    .pc_write(pw1), .ifid_write(iw1), .ifid_flush(if1), .exmem_flush(ef1),
    .state_o(st1), .stall_cnt(sc1), .flush_cnt(fc1));

  hazard_detection_unit #(.STALL_CYCLES(3), .CNT_W(16)) u3 (
    .clk(clk), .rst_n(rst_n), .idex_mem_read(mr), .idex_rt(irt), .ifid_rs(rs),
    .ifid_rt(rt), .ifid_uses_rt(use_rt), .branch_taken(bt), .ctrl_sel(cs3),
    .pc_write(pw3), .ifid_write(iw3), .ifid_flush(if3), .exmem_flush(ef3),
    .state_o(st3), .stall_cnt(sc3), .flush_cnt(fc3));

  hazard_detection_unit #(.STALL_CYCLES(1), .CNT_W(4)) u4 (
    .clk(clk), .rst_n(rst_n), .idex_mem_read(mr), .idex_rt(irt), .ifid_rs(rs),
    .ifid_rt(rt), .ifid_uses_rt(use_rt), .branch_taken(bt), .ctrl_sel(cs4),
    .pc_write(pw4), .ifid_write(iw4), .ifid_flush(if4), .exmem_flush(ef4),
    .state_o(st4), .stall_cnt(sc4), .flush_cnt(fc4));

  // {ctrl_sel, pc_write, ifid_write, ifid_flush, exmem_flush}
  typedef logic [4:0] outs_t;
  localparam outs_t PASS  = 5'b11100;
  localparam outs_t STALL = 5'b00000;
  localparam outs_t FLUSH = 5'b01111;

  typedef struct {
    logic       mr;
    logic [4:0] irt, rs, rt;
    logic       use_rt, bt;
    outs_t      exp;
  } vec_t;

  localparam int NV = 11;
  vec_t  tbl [NV];
  outs_t sb_q [$];
  int    st_q [$];

  function automatic vec_t mk(input logic m, input int a, input int b, input int c,
                              input logic u, input logic t, input outs_t e);
    vec_t v;
    v.mr = m; v.irt = 5'(a); v.rs = 5'(b); v.rt = 5'(c);
    v.use_rt = u; v.bt = t; v.exp = e;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic m, input int a, input int b, input int c,
                       input logic u, input logic t);
    mr = m; irt = 5'(a); rs = 5'(b); rt = 5'(c); use_rt = u; bt = t;
  endtask

  task automatic step(input logic m, input int a, input int b, input int c,
                      input logic u, input logic t);
    @(posedge clk);
    #1;
    drive(m, a, b, c, u, t);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    outs_t e;
    int    es;

    tbl[0]  = mk(0, 0, 0, 0, 0, 0, PASS);   // idle
    tbl[1]  = mk(1, 2, 2, 0, 1, 0, STALL);  // lw $2 ; add uses rs=$2
    tbl[2]  = mk(1, 0, 0, 0, 1, 0, PASS);   // $zero never hazards
    tbl[3]  = mk(1, 5, 3, 5, 0, 0, PASS);   // rt match but rt unused
    tbl[4]  = mk(1, 5, 3, 5, 1, 0, STALL);  // rt match and used
    tbl[5]  = mk(0, 2, 2, 0, 0, 0, PASS);   // not a load
    tbl[6]  = mk(1, 2, 2, 0, 0, 1, FLUSH);  // hazard and branch together
    tbl[7]  = mk(0, 0, 0, 0, 0, 0, PASS);   // FLUSH state, no hazard
    tbl[8]  = mk(0, 0, 0, 0, 0, 1, FLUSH);  // branch only
    tbl[9]  = mk(1, 7, 7, 0, 0, 0, STALL);  // hazard seen in FLUSH state
    tbl[10] = mk(0, 0, 0, 0, 0, 0, PASS);

    // reset state, with a branch asserted that must be ignored
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_outs", {cs1, pw1, iw1, if1, ef1}, 5'b00000);
    chk("rst_state", st1, 0);
    chk("rst_stall_cnt", sc1, 0);
    chk("rst_flush_cnt", fc1, 0);
    bt = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("bt_in_reset_ignored", fc1, 0);
    chk("post_rst_state", st1, 0);

    for (int i = 0; i < NV; i++) begin
      @(posedge clk);
      #1;
      drive(tbl[i].mr, int'(tbl[i].irt), int'(tbl[i].rs), int'(tbl[i].rt),
            tbl[i].use_rt, tbl[i].bt);
      sb_q.push_back(tbl[i].exp);
      @(negedge clk);
      e = sb_q.pop_front();
      chk($sformatf("vec%0d", i), {cs1, pw1, iw1, if1, ef1}, e);
    end
    step(0, 0, 0, 0, 0, 0);
    chk("tbl_stall_cnt", sc1, 3);
    chk("tbl_flush_cnt", fc1, 2);

    // three-bubble hazard: state 0,1,1,0 with stall outputs held until RUN
    do_reset();
    for (int k = 0; k < 4; k++) begin
      if (k == 0) begin
        @(posedge clk); #1; drive(1, 2, 2, 0, 1, 0);
      end else begin
        @(posedge clk); #1; drive(0, 0, 2, 0, 1, 0);
      end
      sb_q.push_back((k == 3) ? PASS : STALL);
      st_q.push_back((k == 1 || k == 2) ? 1 : 0);
      @(negedge clk);
      e  = sb_q.pop_front();
      es = st_q.pop_front();
      chk($sformatf("stall3_outs%0d", k), {cs3, pw3, iw3, if3, ef3}, e);
      chk($sformatf("stall3_state%0d", k), st3, es);
    end
    chk("stall3_cnt", sc3, 3);

    // hazard and branch in the same cycle
    do_reset();
    step(1, 2, 2, 0, 1, 1);
    chk("hz_bt_outs", {cs3, pw3, iw3, if3, ef3}, FLUSH);
    step(0, 0, 0, 0, 0, 0);
    chk("hz_bt_stall_cnt", sc3, 0);
    chk("hz_bt_flush_cnt", fc3, 1);
    chk("hz_bt_state", st3, 2);

    // branch in the second STALL-state cycle aborts the stall
    do_reset();
    step(1, 2, 2, 0, 1, 0);
    step(0, 0, 2, 0, 1, 0);
    step(0, 0, 2, 0, 1, 1);
    chk("abort_state", st3, 1);
    chk("abort_outs", {cs3, pw3, iw3, if3, ef3}, FLUSH);
    step(0, 0, 0, 0, 0, 0);
    chk("abort_flush_state", st3, 2);
    chk("abort_flush_outs", {cs3, pw3, iw3, if3, ef3}, PASS);
    step(0, 0, 0, 0, 0, 0);
    chk("abort_run_state", st3, 0);
    chk("abort_stall_cnt", sc3, 2);
    chk("abort_flush_cnt", fc3, 1);

    // narrow flush counter saturates
    do_reset();
    for (int k = 0; k < 20; k++) step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    chk("sat_flush_cnt", fc4, 15);

    // asynchronous reset in the middle of a stall
    step(1, 2, 2, 0, 1, 0);
    step(0, 0, 2, 0, 1, 0);
    chk("pre_rst_state", st3, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_state", st3, 0);
    chk("midrst_stall_cnt", sc3, 0);
    chk("midrst_flush_cnt", fc4, 0);
    chk("midrst_ctrl", {cs3, pw3, iw3}, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
